// File: rtl/tl45_pkg.sv
// Shared types for the tl45 register scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// NUM_REGS : number of tracked architectural registers (r1..r15; r0 is never tracked)
// reg_idx_t: 4-bit architectural register index
// state_e  : scoreboard recovery state (RUN / DRAIN)
package tl45_pkg;

  localparam int NUM_REGS = 15;

  typedef logic [3:0] reg_idx_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/tl45_sb_counter.sv
// Saturating pending-write counter for one architectural register.
// Latency: count updates on the clock edge after inc/dec; nonzero_o follows the registered count.
// Backpressure: none; the caller must not increment a full counter unless a decrement also hits it.
//
// Ports:
//   clk_i, reset_i   : clock, synchronous active-high reset
//   inc_i            : one new outstanding write
//   dec1_i, dec2_i   : one release each (writeback or squash)
//   force_clr_i      : drop the count to zero (drain timeout); overrides inc/dec
//   cnt_o            : registered count
//   nonzero_o        : count != 0
//   underflow_o      : this cycle's releases exceed count + inc (combinational pulse)
module tl45_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             dec1_i,
  input  logic             dec2_i,
  input  logic             force_clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nonzero_o,
  output logic             underflow_o
);

  // Two guard bits so cnt + inc and dec1 + dec2 can be compared without wrap.
  localparam int W = CNT_W + 2;
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     up_w, dn_w, diff_w;

  always_comb begin
    up_w        = W'(cnt_q) + W'(inc_i);
    dn_w        = W'(dec1_i) + W'(dec2_i);
    diff_w      = up_w - dn_w;
    underflow_o = 1'b0;
    cnt_d       = cnt_q;
    if (force_clr_i) begin
      cnt_d = '0;
    end else if (dn_w > up_w) begin
      // Releasing more writes than are outstanding: clamp at zero and flag it.
      cnt_d       = '0;
      underflow_o = 1'b1;
    end else if (diff_w > W'(MAX)) begin
      cnt_d = MAX;
    end else begin
      cnt_d = diff_w[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/tl45_scoreboard.sv
// Register scoreboard: tracks pending writes to r1..r15, raises operand/saturation stalls, drains after a flush.
// Latency: busy list and idle reflect a set/clear one cycle later; o_stall is combinational from inputs and state.
// Backpressure: o_stall holds fetch/decode/register-read; sets are only accepted when not stalling and not flushing.
//
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_pipe_stall          : downstream stall, passed through to o_stall
//   i_pipe_flush          : pipeline flush, enters DRAIN
//   i_set_reg             : destination to mark busy (0 = none)
//   i_sr1, i_sr2, i_ri    : sources of the instruction in register-read; i_ri skips sr2
//   i_of1_reg, i_of2_reg  : registers currently available on the forwarding buses
//   i_clr1_reg, i_clr2_reg: release ports (writeback / squash), 0 = none
//   o_busylist            : bit n-1 set when register n has pending writes
//   o_stall, o_idle, o_err: stall, all counters zero, sticky underflow/drain-timeout error
module tl45_scoreboard
  import tl45_pkg::*;
#(
  parameter int CNT_W     = 2,
  parameter int DRAIN_MAX = 15
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_pipe_stall,
  input  logic                i_pipe_flush,
  input  logic [3:0]          i_set_reg,
  input  logic [3:0]          i_sr1,
  input  logic [3:0]          i_sr2,
  input  logic                i_ri,
  input  logic [3:0]          i_of1_reg,
  input  logic [3:0]          i_of2_reg,
  input  logic [3:0]          i_clr1_reg,
  input  logic [3:0]          i_clr2_reg,
  output logic [NUM_REGS-1:0] o_busylist,
  output logic                o_stall,
  output logic                o_idle,
  output logic                o_err
);

  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             err_q, err_d;
  logic             force_clr;

  logic [CNT_W-1:0] cnt_v [1:NUM_REGS];
  logic [NUM_REGS:1] busy_v;
  logic [NUM_REGS:1] underflow_v;
  logic [15:0]      busy_idx;     // busy_idx[n] = register n busy; r0 never busy
  logic [CNT_W-1:0] set_cnt;
  logic             hazard1, hazard2, sat, set_ok, set_released;

  // Per-register counters
  for (genvar n = 1; n <= NUM_REGS; n++) begin : g_cnt
    tl45_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i      (i_clk),
      .reset_i    (i_reset),
      .inc_i      (set_ok && (i_set_reg == reg_idx_t'(n))),
      .dec1_i     (i_clr1_reg == reg_idx_t'(n)),
      .dec2_i     (i_clr2_reg == reg_idx_t'(n)),
      .force_clr_i(force_clr),
      .cnt_o      (cnt_v[n]),
      .nonzero_o  (busy_v[n]),
      .underflow_o(underflow_v[n])
    );
  end

  assign busy_idx   = {busy_v, 1'b0};
  assign o_busylist = busy_v;
  assign o_idle     = ~|busy_v;
  assign o_err      = err_q;

  // Operand hazards: a busy source stalls unless a forwarding bus carries it this cycle.
  assign hazard1 = (i_sr1 != '0) && busy_idx[i_sr1] &&
                   (i_of1_reg != i_sr1) && (i_of2_reg != i_sr1);
  assign hazard2 = !i_ri && (i_sr2 != '0) && busy_idx[i_sr2] &&
                   (i_of1_reg != i_sr2) && (i_of2_reg != i_sr2);

  always_comb begin
    set_cnt = '0;
    for (int n = 1; n <= NUM_REGS; n++) begin
      if (i_set_reg == reg_idx_t'(n)) set_cnt = cnt_v[n];
    end
  end

  // A full counter can still take a set when a release frees a slot in the same cycle.
  assign set_released = (i_clr1_reg == i_set_reg) || (i_clr2_reg == i_set_reg);
  assign sat          = (i_set_reg != '0) && (set_cnt == CNT_MAX) && !set_released;

  assign o_stall = i_pipe_stall | hazard1 | hazard2 | sat | (state_q == DRAIN);
  assign set_ok  = (state_q == RUN) && !o_stall && !i_pipe_flush && (i_set_reg != '0);

  // Recovery FSM
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    force_clr = 1'b0;
    case (state_q)
      RUN: begin
        if (i_pipe_flush) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (i_pipe_flush) begin
          drain_d = '0;
        end else if (o_idle) begin
          state_d = RUN;
        end else if (drain_q == DW'(DRAIN_MAX)) begin
          // Releases never arrived: drop all tracking rather than hang the front end.
          force_clr = 1'b1;
          state_d   = RUN;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign err_d = err_q | (|underflow_v) | force_clr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

endmodule
